// File: rtl/adc_spi_slave_3w.sv
// ---------------------------------------------------------------------------
// adc_spi_slave_3w
//
// Three-wire SPI responder modelling an ADC configuration port. Frames arrive
// on a shared SDIO line: a 16-bit instruction (R/W bit, two ignored bits,
// 13-bit start address) followed by data bytes until chip select rises. Writes
// land in an internal 8-bit register file. Reads shift data back out on SDIO.
// The address decrements after every completed byte (streaming).
// All SPI inputs are asynchronous to clk and are oversampled.
//
// Ports
//   clk      : system clock, at least 8x the sck frequency
//   resetn   : asynchronous active-low reset
//   sck      : SPI clock, idle low, mode 0
//   csn      : chip select, active low
//   sdio_i   : SDIO value from the IOBUF
//   sdio_o   : SDIO drive value
//   sdio_oe  : SDIO output enable (1 drives the line)
//   wr_stb   : one-cycle pulse per committed register write
//   wr_addr  : address of the committed write
//   wr_data  : data of the committed write
//   rd_addr  : local read address
//   rd_data  : registered local read data (1-cycle latency)
// ---------------------------------------------------------------------------
module adc_spi_slave_3w #(
  parameter int          ADDR_BITS   = 4,
  parameter logic [7:0]  CHIP_ID     = 8'h05,
  parameter int          SYNC_STAGES = 2
) (
  input  logic                 clk,
  input  logic                 resetn,
  input  logic                 sck,
  input  logic                 csn,
  input  logic                 sdio_i,
  output logic                 sdio_o,
  output logic                 sdio_oe,
  output logic                 wr_stb,
  output logic [ADDR_BITS-1:0] wr_addr,
  output logic [7:0]           wr_data,
  input  logic [ADDR_BITS-1:0] rd_addr,
  output logic [7:0]           rd_data
);

  localparam int NUM_REGS = 1 << ADDR_BITS;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_INSTR,
    ST_DATA
  } state_t;

  state_t r_state;
  state_t w_nextState;

  logic [SYNC_STAGES-1:0] r_sckSync;
  logic [SYNC_STAGES-1:0] r_csnSync;
  logic [SYNC_STAGES-1:0] r_sdioSync;
  logic                   r_sckHist;
  logic                   r_csnHist;

  logic [3:0]           r_bitCnt;
  logic [2:0]           r_txCnt;
  logic [14:0]          r_shift;
  logic [7:0]           r_txByte;
  logic [12:0]          r_addr;
  logic                 r_rw;
  logic                 r_sdioO;
  logic                 r_sdioOe;
  logic                 r_wrStb;
  logic [ADDR_BITS-1:0] r_wrAddr;
  logic [7:0]           r_wrData;
  logic [7:0]           r_rdData;
  logic [7:0]           r_regs [NUM_REGS];

  logic       w_sck;
  logic       w_csn;
  logic       w_sdio;
  logic       w_sckRise;
  logic       w_sckFall;
  logic       w_csnFall;
  logic       w_inRange;
  logic       w_isId;
  logic       w_writable;
  logic [7:0] w_rxByte;
  logic [7:0] w_spiRead;
  logic [7:0] w_localRead;

  // The csn synchronizer and history reset low: after a reset with csn already
  // low no falling edge is seen, so a frame only starts once csn has been
  // high and then low again.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_sckSync  <= '0;
      r_csnSync  <= '0;
      r_sdioSync <= '0;
      r_sckHist  <= 1'b0;
      r_csnHist  <= 1'b0;
    end else begin
      r_sckSync  <= {r_sckSync[SYNC_STAGES-2:0], sck};
      r_csnSync  <= {r_csnSync[SYNC_STAGES-2:0], csn};
      r_sdioSync <= {r_sdioSync[SYNC_STAGES-2:0], sdio_i};
      r_sckHist  <= r_sckSync[SYNC_STAGES-1];
      r_csnHist  <= r_csnSync[SYNC_STAGES-1];
    end
  end

  assign w_sck     = r_sckSync[SYNC_STAGES-1];
  assign w_csn     = r_csnSync[SYNC_STAGES-1];
  assign w_sdio    = r_sdioSync[SYNC_STAGES-1];
  assign w_sckRise = w_sck & ~r_sckHist;
  assign w_sckFall = ~w_sck & r_sckHist;
  assign w_csnFall = ~w_csn & r_csnHist;

  // Addresses above the register file read as zero and ignore writes; the
  // chip-ID address is read-only.
  assign w_inRange   = (r_addr >> ADDR_BITS) == 13'd0;
  assign w_isId      = (r_addr == 13'd1);
  assign w_writable  = w_inRange & ~w_isId;
  assign w_rxByte    = {r_shift[6:0], w_sdio};
  assign w_spiRead   = !w_inRange ? 8'h00 :
                       w_isId     ? CHIP_ID : r_regs[r_addr[ADDR_BITS-1:0]];
  assign w_localRead = (rd_addr == ADDR_BITS'(1)) ? CHIP_ID : r_regs[rd_addr];

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  always_comb begin
    w_nextState = r_state;
    case (r_state)
      ST_IDLE:  if (w_csnFall) w_nextState = ST_INSTR;
      ST_INSTR: if (w_sckRise && r_bitCnt == 4'd15) w_nextState = ST_DATA;
      ST_DATA:  w_nextState = ST_DATA;
      default:  w_nextState = ST_IDLE;
    endcase
    if (w_csn) begin
      w_nextState = ST_IDLE;
    end
  end

  // Read bytes are fetched on the first fall of each byte (r_txCnt == 0), so
  // the first fetch uses the instruction address and later ones see the
  // address already decremented by the previous byte's last rise.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_bitCnt <= '0;
      r_txCnt  <= '0;
      r_shift  <= '0;
      r_txByte <= '0;
      r_addr   <= '0;
      r_rw     <= 1'b0;
      r_sdioO  <= 1'b0;
      r_sdioOe <= 1'b0;
      r_wrStb  <= 1'b0;
      r_wrAddr <= '0;
      r_wrData <= '0;
      r_rdData <= '0;
      for (int i = 0; i < NUM_REGS; i++) begin
        r_regs[i] <= '0;
      end
    end else begin
      r_wrStb  <= 1'b0;
      r_rdData <= w_localRead;
      if (w_csn) begin
        r_bitCnt <= '0;
        r_txCnt  <= '0;
        r_sdioOe <= 1'b0;
      end else begin
        case (r_state)
          ST_INSTR: begin
            if (w_sckRise) begin
              r_shift <= {r_shift[13:0], w_sdio};
              if (r_bitCnt == 4'd15) begin
                r_rw     <= r_shift[14];
                r_addr   <= {r_shift[11:0], w_sdio};
                r_bitCnt <= '0;
                r_txCnt  <= '0;
              end else begin
                r_bitCnt <= r_bitCnt + 4'd1;
              end
            end
          end
          ST_DATA: begin
            if (w_sckRise) begin
              r_shift <= {r_shift[13:0], w_sdio};
              if (r_bitCnt == 4'd7) begin
                r_bitCnt <= '0;
                r_addr   <= r_addr - 13'd1;
                if (!r_rw && w_writable) begin
                  r_regs[r_addr[ADDR_BITS-1:0]] <= w_rxByte;
                  r_wrStb  <= 1'b1;
                  r_wrAddr <= r_addr[ADDR_BITS-1:0];
                  r_wrData <= w_rxByte;
                end
              end else begin
                r_bitCnt <= r_bitCnt + 4'd1;
              end
            end
            if (w_sckFall && r_rw) begin
              r_sdioOe <= 1'b1;
              if (r_txCnt == 3'd0) begin
                r_sdioO  <= w_spiRead[7];
                r_txByte <= {w_spiRead[6:0], 1'b0};
              end else begin
                r_sdioO  <= r_txByte[7];
                r_txByte <= {r_txByte[6:0], 1'b0};
              end
              r_txCnt <= r_txCnt + 3'd1;
            end
          end
          default: begin
            r_bitCnt <= '0;
            r_txCnt  <= '0;
          end
        endcase
      end
    end
  end

  assign sdio_o  = r_sdioO;
  assign sdio_oe = r_sdioOe;
  assign wr_stb  = r_wrStb;
  assign wr_addr = r_wrAddr;
  assign wr_data = r_wrData;
  assign rd_data = r_rdData;

endmodule

// File: tb/tb_adc_spi_slave_3w.sv
// ---------------------------------------------------------------------------
// tb_adc_spi_slave_3w
//
// Drives SPI frames into adc_spi_slave_3w and compares read data, write
// strobes, output-enable behaviour and local reads against a byte-level
// model of the register file kept in this bench.
// ---------------------------------------------------------------------------
module tb_adc_spi_slave_3w;

  localparam int         HALF    = 8;
  localparam logic [7:0] CHIP_ID = 8'h05;

  logic       clk    = 1'b0;
  logic       resetn = 1'b0;
  logic       sck    = 1'b0;
  logic       csn    = 1'b1;
  logic       sdio_i = 1'b0;
  logic       sdio_o;
  logic       sdio_oe;
  logic       wr_stb;
  logic [3:0] wr_addr;
  logic [7:0] wr_data;
  logic [3:0] rd_addr = 4'd0;
  logic [7:0] rd_data;

  int checks = 0;
  int errors = 0;

  logic [7:0]  modelRegs [16];
  logic [11:0] stbQ [$];
  logic [11:0] expQ [$];

  adc_spi_slave_3w #(
    .ADDR_BITS   (4),
    .CHIP_ID     (CHIP_ID),
    .SYNC_STAGES (2)
  ) dut (
    .clk     (clk),
    .resetn  (resetn),
    .sck     (sck),
    .csn     (csn),
    .sdio_i  (sdio_i),
    .sdio_o  (sdio_o),
    .sdio_oe (sdio_oe),
    .wr_stb  (wr_stb),
    .wr_addr (wr_addr),
    .wr_data (wr_data),
    .rd_addr (rd_addr),
    .rd_data (rd_data)
  );

  // Free-running system clock, 10 ns period.
  always #5 clk = ~clk;

  // Every cycle the strobe is high logs one {addr, data} entry, so a strobe
  // wider than one cycle shows up as an extra entry.
  always @(negedge clk) begin
    if (resetn && wr_stb === 1'b1) stbQ.push_back({wr_addr, wr_data});
  end

  // Hard time limit so the run always ends.
  initial begin
    #3ms;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  // Register-file read as seen over SPI: out of range is zero, address 1 is
  // the chip ID.
  function automatic logic [7:0] model_read(input logic [12:0] a);
    if (a >= 13'd16) return 8'h00;
    if (a == 13'd1) return CHIP_ID;
    return modelRegs[a[3:0]];
  endfunction

  // Applies a complete frame to the model: writes update the registers and
  // queue the expected strobes, reads return the expected bytes (MSB-aligned).
  task automatic model_frame(input logic [15:0] instr, input int nBytes,
                             input logic [31:0] wData, output logic [31:0] expRead);
    logic [12:0] a;
    logic [7:0]  b;
    a = instr[12:0];
    expRead = '0;
    for (int k = 0; k < nBytes; k++) begin
      b = wData[31-8*k -: 8];
      if (instr[15]) begin
        expRead[31-8*k -: 8] = model_read(a);
      end else if (a < 13'd16 && a != 13'd1) begin
        modelRegs[a[3:0]] = b;
        expQ.push_back({a[3:0], b});
      end
      a = a - 13'd1;
    end
  endtask

  // Mode-0 SPI master. Samples sdio_o/sdio_oe just before each rise and
  // counts output-enable violations. abortAfter stops after that many bits;
  // holdCsn leaves csn low at the end.
  task automatic spi_frame(input logic [15:0] instr, input int nBytes,
                           input logic [31:0] wData, input int abortAfter,
                           input bit holdCsn, output logic [31:0] rData,
                           output int oeBad, output logic oeAfter);
    oeBad = 0;
    rData = '0;
    oeAfter = 1'b0;
    csn = 1'b0;
    repeat (HALF) @(posedge clk);
    #1;
    for (int i = 0; i < 16 + 8*nBytes; i++) begin
      if (i == abortAfter) break;
      sdio_i = (i < 16) ? instr[15-i] : wData[31-(i-16)];
      repeat (HALF) @(posedge clk);
      #1;
      if (i >= 16 && instr[15]) begin
        rData[31-(i-16)] = sdio_o;
        if (sdio_oe !== 1'b1) oeBad++;
      end else if (sdio_oe !== 1'b0) begin
        oeBad++;
      end
      sck = 1'b1;
      repeat (HALF) @(posedge clk);
      #1;
      sck = 1'b0;
    end
    repeat (HALF) @(posedge clk);
    #1;
    sdio_i = 1'b0;
    if (!holdCsn) begin
      csn = 1'b1;
      repeat (6) @(posedge clk);
      #1;
      oeAfter = sdio_oe;
      repeat (2*HALF) @(posedge clk);
      #1;
    end
  endtask

  task automatic local_read(input logic [3:0] a, output logic [7:0] v);
    rd_addr = a;
    @(posedge clk);
    #1;
    v = rd_data;
  endtask

  task automatic test_reset;
    logic [7:0] v;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({sdio_o, sdio_oe, wr_stb} !== 3'b000) begin
      errors++;
      $display("[TB] FAIL reset_ctrl: got %b expected 000", {sdio_o, sdio_oe, wr_stb});
    end
    checks++;
    if ({wr_addr, wr_data, rd_data} !== 20'h0) begin
      errors++;
      $display("[TB] FAIL reset_data: got %h expected 00000", {wr_addr, wr_data, rd_data});
    end
    for (int i = 0; i < 16; i++) modelRegs[i] = 8'h00;
    resetn = 1'b1;
    repeat (4) @(posedge clk);
    local_read(4'd7, v);
    checks++;
    if (v !== 8'h00) begin
      errors++;
      $display("[TB] FAIL reset_reg7: got %h expected 00", v);
    end
  endtask

  task automatic test_write_read;
    logic [31:0] exp, rd;
    int ob;
    logic oa;
    logic [7:0] v;
    stbQ.delete(); expQ.delete();
    model_frame(16'h0005, 1, 32'hA500_0000, exp);
    spi_frame(16'h0005, 1, 32'hA500_0000, -1, 0, rd, ob, oa);
    checks++;
    if (stbQ.size() != 1 || stbQ[0] !== 12'h5A5) begin
      errors++;
      $display("[TB] FAIL write5_strobe: got n=%0d first=%h expected n=1 5a5",
               stbQ.size(), (stbQ.size() > 0) ? stbQ[0] : 12'hxxx);
    end
    checks++;
    if (ob != 0) begin
      errors++;
      $display("[TB] FAIL write5_oe: got %0d drive samples expected 0", ob);
    end
    local_read(4'd5, v);
    checks++;
    if (v !== 8'hA5) begin
      errors++;
      $display("[TB] FAIL local5: got %h expected a5", v);
    end
  endtask

  task automatic test_read;
    logic [31:0] exp, rd;
    int ob;
    logic oa;
    stbQ.delete(); expQ.delete();
    model_frame(16'h8005, 1, 32'h0, exp);
    spi_frame(16'h8005, 1, 32'h0, -1, 0, rd, ob, oa);
    checks++;
    if (rd[31:24] !== 8'hA5) begin
      errors++;
      $display("[TB] FAIL read5_data: got %h expected a5", rd[31:24]);
    end
    checks++;
    if (ob != 0 || oa !== 1'b0 || stbQ.size() != 0) begin
      errors++;
      $display("[TB] FAIL read5_oe: got bad=%0d after=%b stb=%0d expected 0 0 0",
               ob, oa, stbQ.size());
    end
  endtask

  task automatic test_chip_id;
    logic [31:0] exp, rd;
    int ob;
    logic oa;
    stbQ.delete(); expQ.delete();
    spi_frame(16'h8001, 1, 32'h0, -1, 0, rd, ob, oa);
    checks++;
    if (rd[31:24] !== 8'h05 || ob != 0) begin
      errors++;
      $display("[TB] FAIL chip_id: got %h bad=%0d expected 05 0", rd[31:24], ob);
    end
    model_frame(16'h0001, 1, 32'hFF00_0000, exp);
    spi_frame(16'h0001, 1, 32'hFF00_0000, -1, 0, rd, ob, oa);
    checks++;
    if (stbQ.size() != 0) begin
      errors++;
      $display("[TB] FAIL chip_id_wr: got %0d strobes expected 0", stbQ.size());
    end
    spi_frame(16'h8001, 1, 32'h0, -1, 0, rd, ob, oa);
    checks++;
    if (rd[31:24] !== 8'h05) begin
      errors++;
      $display("[TB] FAIL chip_id_reread: got %h expected 05", rd[31:24]);
    end
  endtask

  task automatic test_stream;
    logic [31:0] exp, rd;
    int ob;
    logic oa;
    logic [7:0] v;
    stbQ.delete(); expQ.delete();
    model_frame(16'h0003, 2, 32'h1122_0000, exp);
    spi_frame(16'h0003, 2, 32'h1122_0000, -1, 0, rd, ob, oa);
    checks++;
    if (stbQ.size() != 2 || stbQ[0] !== 12'h311 || stbQ[1] !== 12'h222) begin
      errors++;
      $display("[TB] FAIL stream_wr: got n=%0d expected 311,222", stbQ.size());
    end
    spi_frame(16'h8003, 3, 32'h0, -1, 0, rd, ob, oa);
    checks++;
    if (rd !== 32'h1122_0500 || ob != 0) begin
      errors++;
      $display("[TB] FAIL stream_rd: got %h bad=%0d expected 11220500 0", rd, ob);
    end
    stbQ.delete(); expQ.delete();
    model_frame(16'h0000, 2, 32'h3344_0000, exp);
    spi_frame(16'h0000, 2, 32'h3344_0000, -1, 0, rd, ob, oa);
    checks++;
    if (stbQ.size() != 1 || stbQ[0] !== 12'h033) begin
      errors++;
      $display("[TB] FAIL stream_wrap: got n=%0d expected single 033", stbQ.size());
    end
    local_read(4'd15, v);
    checks++;
    if (v !== 8'h00) begin
      errors++;
      $display("[TB] FAIL stream_wrap_reg15: got %h expected 00", v);
    end
  endtask

  task automatic test_abort;
    logic [31:0] exp, rd;
    int ob;
    logic oa;
    logic [7:0] v;
    stbQ.delete(); expQ.delete();
    spi_frame(16'h8005, 1, 32'h0, 10, 0, rd, ob, oa);
    checks++;
    if (ob != 0 || oa !== 1'b0 || stbQ.size() != 0) begin
      errors++;
      $display("[TB] FAIL abort_instr: got bad=%0d after=%b stb=%0d expected 0 0 0",
               ob, oa, stbQ.size());
    end
    model_frame(16'h0006, 1, 32'h5A00_0000, exp);
    spi_frame(16'h0006, 1, 32'h5A00_0000, -1, 0, rd, ob, oa);
    checks++;
    if (stbQ.size() != 1 || stbQ[0] !== 12'h65A) begin
      errors++;
      $display("[TB] FAIL after_abort: got n=%0d expected single 65a", stbQ.size());
    end
    stbQ.delete();
    spi_frame(16'h0006, 1, 32'hC300_0000, 21, 0, rd, ob, oa);
    local_read(4'd6, v);
    checks++;
    if (stbQ.size() != 0 || v !== 8'h5A) begin
      errors++;
      $display("[TB] FAIL abort_data: got stb=%0d reg=%h expected 0 5a", stbQ.size(), v);
    end
  endtask

  task automatic test_out_of_range;
    logic [31:0] exp, rd;
    int ob;
    logic oa;
    logic [7:0] v;
    stbQ.delete(); expQ.delete();
    model_frame(16'h0100, 1, 32'h7700_0000, exp);
    spi_frame(16'h0100, 1, 32'h7700_0000, -1, 0, rd, ob, oa);
    local_read(4'd0, v);
    checks++;
    if (stbQ.size() != 0 || v !== 8'h33) begin
      errors++;
      $display("[TB] FAIL oor_write: got stb=%0d reg0=%h expected 0 33", stbQ.size(), v);
    end
    spi_frame(16'h8100, 1, 32'h0, -1, 0, rd, ob, oa);
    checks++;
    if (rd[31:24] !== 8'h00 || ob != 0) begin
      errors++;
      $display("[TB] FAIL oor_read: got %h bad=%0d expected 00 0", rd[31:24], ob);
    end
  endtask

  task automatic test_random;
    logic [31:0] exp, rd, wd;
    logic [15:0] instr;
    logic [12:0] a;
    logic [7:0]  v, ev;
    logic [3:0]  la;
    int n, ob;
    logic oa;
    for (int it = 0; it < 24; it++) begin
      stbQ.delete(); expQ.delete();
      a = ($urandom_range(0, 5) == 0) ? 13'($urandom) : 13'($urandom_range(0, 15));
      instr = {1'($urandom_range(0, 1)), 2'($urandom), a};
      n = $urandom_range(1, 3);
      wd = $urandom;
      model_frame(instr, n, wd, exp);
      spi_frame(instr, n, wd, -1, 0, rd, ob, oa);
      checks++;
      if (instr[15] && rd !== exp) begin
        errors++;
        $display("[TB] FAIL rand_read[%0d] %h: got %h expected %h", it, instr, rd, exp);
      end
      checks++;
      if (ob != 0 || oa !== 1'b0) begin
        errors++;
        $display("[TB] FAIL rand_oe[%0d] %h: got bad=%0d after=%b expected 0 0", it, instr, ob, oa);
      end
      checks++;
      if (stbQ.size() != expQ.size()) begin
        errors++;
        $display("[TB] FAIL rand_stbcount[%0d] %h: got %0d expected %0d",
                 it, instr, stbQ.size(), expQ.size());
      end else begin
        for (int k = 0; k < expQ.size(); k++) begin
          checks++;
          if (stbQ[k] !== expQ[k]) begin
            errors++;
            $display("[TB] FAIL rand_stb[%0d.%0d]: got %h expected %h", it, k, stbQ[k], expQ[k]);
          end
        end
      end
      la = 4'($urandom);
      ev = (la == 4'd1) ? CHIP_ID : modelRegs[la];
      local_read(la, v);
      checks++;
      if (v !== ev) begin
        errors++;
        $display("[TB] FAIL rand_local[%0d] addr %h: got %h expected %h", it, la, v, ev);
      end
    end
  endtask

  task automatic test_reset_mid_frame;
    logic [31:0] rd;
    int ob;
    logic oa;
    logic [7:0] v, ev;
    stbQ.delete(); expQ.delete();
    rd_addr = 4'd0;
    spi_frame(16'h8000, 1, 32'h0, 20, 1, rd, ob, oa);
    #3;
    resetn = 1'b0;
    #1;
    checks++;
    if ({sdio_o, sdio_oe, wr_stb, wr_addr, wr_data, rd_data} !== 23'h0) begin
      errors++;
      $display("[TB] FAIL reset_mid: got %b%b%b %h %h %h expected all zero",
               sdio_o, sdio_oe, wr_stb, wr_addr, wr_data, rd_data);
    end
    for (int i = 0; i < 16; i++) modelRegs[i] = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    resetn = 1'b1;
    ob = 0;
    for (int i = 0; i < 24; i++) begin
      sdio_i = 1'($urandom);
      repeat (HALF) @(posedge clk);
      #1;
      if (sdio_oe !== 1'b0) ob++;
      sck = 1'b1;
      repeat (HALF) @(posedge clk);
      #1;
      sck = 1'b0;
    end
    csn = 1'b1;
    repeat (2*HALF) @(posedge clk);
    #1;
    checks++;
    if (ob != 0 || stbQ.size() != 0) begin
      errors++;
      $display("[TB] FAIL post_reset_idle: got bad=%0d stb=%0d expected 0 0", ob, stbQ.size());
    end
    spi_frame(16'h8005, 1, 32'h0, -1, 0, rd, ob, oa);
    checks++;
    if (rd[31:24] !== 8'h00 || ob != 0) begin
      errors++;
      $display("[TB] FAIL post_reset_read5: got %h bad=%0d expected 00 0", rd[31:24], ob);
    end
    for (int i = 0; i < 16; i++) begin
      ev = (i == 1) ? CHIP_ID : modelRegs[i];
      local_read(4'(i), v);
      checks++;
      if (v !== ev) begin
        errors++;
        $display("[TB] FAIL post_reset_reg[%0d]: got %h expected %h", i, v, ev);
      end
    end
  endtask

  // Scenarios run in order; later ones rely on register contents left by
  // earlier ones (e.g. reg0 = 0x33 from the streaming write).
  initial begin
    test_reset();
    test_write_read();
    test_read();
    test_chip_id();
    test_stream();
    test_abort();
    test_out_of_range();
    test_random();
    test_reset_mid_frame();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end

endmodule

// File: doc/adc_spi_slave_3w.md
# adc_spi_slave_3w

Three-wire SPI responder that models the ADC's configuration port: it receives instruction/data frames on a shared SDIO line from the SPI wrapper, writes an internal 8-bit register file and drives read data back onto SDIO. It sits behind the top-level IOBUF, both as the simulation counterpart of the wrapper and as an in-FPGA register target. All SPI inputs are asynchronous to `clk` and are oversampled.

## Interface

- `ADDR_BITS`, 4: register file holds 2^ADDR_BITS 8-bit registers.
- `CHIP_ID`, 8'h05: read-only value at address 0x001.
- `SYNC_STAGES`, 2: synchronizer depth on `sck`, `csn` and `sdio_i`; minimum 2.

- `clk` in 1: system clock; must be at least 8× the `sck` frequency.
- `resetn` in 1: asynchronous, active-low reset.
- `sck` in 1: SPI clock, idle low, mode 0.
- `csn` in 1: chip select, active low.
- `sdio_i` in 1: SDIO input from the IOBUF.
- `sdio_o` out 1: SDIO drive value.
- `sdio_oe` out 1: SDIO output enable; 1 drives the line.
- `wr_stb` out 1: one-cycle pulse per committed register write.
- `wr_addr` out ADDR_BITS: address of the committed write.
- `wr_data` out 8: data of the committed write.
- `rd_addr` in ADDR_BITS: local read address.
- `rd_data` out 8: registered local read data, 1-cycle latency.

## Operation

- Inputs pass through SYNC_STAGES flops, then one history flop for edge detection.
  - `sck_rise` samples SDIO.
  - `sck_fall` updates `sdio_o`.
- Frame, MSB first:
  - 16-bit instruction: bit15 R/W (1 = read), bits14:13 ignored, bits12:0 address A.
  - Then data bytes until `csn` rises.
- State machine:
  - IDLE: waits for `csn` low, then goes to INSTR with bit_cnt = 0.
  - INSTR: shifts 16 bits, then goes to DATA.
  - DATA: 8 bits per byte. bit_cnt wraps 7→0 per byte.
  - A synchronized `csn` high in any state forces IDLE, clears bit_cnt, clears `sdio_oe` and discards any partial byte.
- Address handling:
  - The current address starts at A.
  - It decrements after each completed byte, modulo 2^13.
  - An address is in range when A[12:ADDR_BITS] == 0.
- Write, on the 8th data `sck_rise` of each byte:
  - The shifted byte is written to the register file.
  - `wr_stb`/`wr_addr`/`wr_data` are valid in the cycle after that edge.
  - No write and no strobe for out-of-range addresses or address 0x001.
- Read:
  - On the `sck_fall` after the 16th instruction rise, `sdio_oe` goes to 1 and `sdio_o` carries data bit7.
  - Each following `sck_fall` shifts out the next bit.
  - After bit0, the next byte is loaded from the decremented address.
  - Out-of-range addresses return 0x00; address 0x001 returns CHIP_ID.
- Reset state:
  - All registers 0x00.
  - `sdio_o`=0, `sdio_oe`=0, `wr_stb`=0, `wr_addr`=0, `wr_data`=0, `rd_data`=0.
  - State machine in IDLE.
- Simultaneous SPI write and local read of the same address: `rd_data` returns the old value that cycle and the new value the next cycle.

## Timing

- Raw `sck` edge to internal detect: SYNC_STAGES+1 `clk` cycles.
- Raw `sck_fall` to `sdio_o` update: SYNC_STAGES+2 cycles. This must be below half an `sck` period, which sets the 8× ratio.
- Last data rise to `wr_stb`: SYNC_STAGES+2 cycles, 1 cycle wide.
- Raw `csn` rise to `sdio_oe`=0: SYNC_STAGES+2 cycles.
- `resetn` assertion clears all outputs immediately. Deassertion mid-frame: the block stays in IDLE until `csn` has been seen high and then low again.
- `sdio_oe` is never 1 during the instruction phase or for a write frame.

## Test plan

- Write frame 0x0005, data 0xA5 → `wr_stb` pulse with `wr_addr`=5, `wr_data`=0xA5; `rd_addr`=5 yields `rd_data`=0xA5.
- Read frame 0x8005 after that write → `sdio_oe` rises after the 16th `sck_fall`; serial data is 1010_0101; `sdio_oe`=0 after `csn` rises.
- Read 0x8001 → 0x05 (CHIP_ID). Then write 0x0001 with 0xFF → no `wr_stb`; re-read still returns 0x05.
- Streaming read from 0x8003 with registers 3=0x11, 2=0x22, 1=ID → bytes 0x11, 0x22, 0x05. Streaming write from 0x0000 with 0x33, 0x44 → reg0=0x33 and reg 0x1FFF is out of range, so it is ignored.
- Abort cases:
  - `csn` rises after 10 instruction bits → no strobe, no drive. The next complete frame decodes correctly.
  - `csn` rises after 5 data bits of a write → register unchanged.
- Out of range, and reset during a frame:
  - Write 0x0100 with 0x77 → no strobe. Read 0x8100 → 0x00.
  - `resetn` low during the data phase → all outputs and registers go to 0 immediately.
